// File: rtl/idu_imm_sched.sv
// Decode-stage in-order queue between IFU and EXU: classifies the immediate type at enqueue,
// issues the head with its sign-extended immediate, supports flush and counts EXU stall cycles.
module idu_imm_sched #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [63:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic [2:0]       out_imm_sel,
  output logic [63:0]      out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_I    = 3'd1;
  localparam logic [2:0] SEL_U    = 3'd2;
  localparam logic [2:0] SEL_S    = 3'd3;
  localparam logic [2:0] SEL_J    = 3'd4;
  localparam logic [2:0] SEL_B    = 3'd5;

  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [63:0]      pcMem    [DEPTH];
  logic [31:0]      instrMem [DEPTH];
  logic [2:0]       selMem   [DEPTH];
  logic             illMem   [DEPTH];
  logic [CNT_W-1:0] stallCnt;

  logic       doPush;
  logic       doPop;
  logic [2:0] inSel;
  logic       inIllegal;
  logic [31:0] headInstr;

  assign in_ready  = (count != FULL_COUNT) && !flush;
  assign out_valid = (count != '0);
  assign doPush    = in_valid && in_ready;
  assign doPop     = out_valid && out_ready;

  // Opcode classification happens on the incoming word so the queue stores it pre-decoded;
  // the full 7-bit match also rejects any word whose low two bits are not 2'b11.
  always_comb begin
    inSel     = SEL_NONE;
    inIllegal = 1'b0;
    case (in_instr[6:0])
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b1110011: inSel = SEL_I;
      7'b0110111, 7'b0010111: inSel = SEL_U;
      7'b0100011: inSel = SEL_S;
      7'b1101111: inSel = SEL_J;
      7'b1100011: inSel = SEL_B;
      7'b0110011, 7'b0111011: inSel = SEL_NONE;
      default: inIllegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcMem[i]    <= '0;
        instrMem[i] <= '0;
        selMem[i]   <= '0;
        illMem[i]   <= 1'b0;
      end
    end else if (flush) begin
      // Entry data stay behind as stale contents; only the bookkeeping is cleared.
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      if (doPush) begin
        pcMem[wrPtr]    <= in_pc;
        instrMem[wrPtr] <= in_instr;
        selMem[wrPtr]   <= inSel;
        illMem[wrPtr]   <= inIllegal;
        wrPtr           <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
    end else if (out_valid && !out_ready && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

  assign headInstr   = instrMem[rdPtr];
  assign out_pc      = pcMem[rdPtr];
  assign out_instr   = headInstr;
  assign out_imm_sel = selMem[rdPtr];
  assign out_illegal = illMem[rdPtr];
  assign stall_cnt   = stallCnt;

  always_comb begin
    out_imm = '0;
    case (selMem[rdPtr])
      SEL_I: out_imm = {{52{headInstr[31]}}, headInstr[31:20]};
      SEL_U: out_imm = {{32{headInstr[31]}}, headInstr[31:12], 12'b0};
      SEL_S: out_imm = {{52{headInstr[31]}}, headInstr[31:25], headInstr[11:7]};
      SEL_J: out_imm = {{43{headInstr[31]}}, headInstr[31], headInstr[19:12],
                        headInstr[20], headInstr[30:21], 1'b0};
      SEL_B: out_imm = {{51{headInstr[31]}}, headInstr[31], headInstr[7],
                        headInstr[30:25], headInstr[11:8], 1'b0};
      default: out_imm = '0;
    endcase
  end

endmodule
